dmem_arbiter: RTL and testbench

Sequencer and two-requester arbiter in front of the 256 x 32 data memory (distributed RAM: synchronous write, asynchronous read). After reset it optionally zero-fills the whole memory, then shares the single RAM port between the CPU data port and a debug/loader port with round-robin fairness. It sits between the CPU datapath and the `DataMemory` RAM instance. It drives the RAM's `we`/`a`/`d` and receives its `spo`.

---
 rtl/dmem_arbiter.sv | 145 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: zero-fills the data RAM after reset, then shares its single
// port between the CPU data port and a debug/loader port with round-robin
// priority on contention.
module dmem_arbiter #(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned DATA_W         = 32,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,

    // CPU data port
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,

    // debug / loader port
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,

    // RAM port
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_d,
    input  logic [DATA_W-1:0] mem_spo,

    output logic              busy_clear
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam state_t            RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
    localparam logic [ADDR_W-1:0] CNT_LAST    = '1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic                prio_q, prio_d;
    logic                dbg_ack_q, dbg_ack_d;
    logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;

    logic                dbg_live;
    logic                cpu_grant;
    logic                dbg_grant;

    // Only the word index of the CPU address reaches the RAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[31:ADDR_W];

    // State, clear counter, priority pointer and debug response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RESET_STATE;
            clr_cnt_q   <= '0;
            prio_q      <= 1'b0;
            dbg_ack_q   <= 1'b0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            prio_q      <= prio_d;
            dbg_ack_q   <= dbg_ack_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    // Next-state, arbitration and RAM port steering.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        prio_d      = prio_q;
        dbg_ack_d   = 1'b0;
        dbg_rdata_d = dbg_rdata_q;
        dbg_live    = 1'b0;
        cpu_grant   = 1'b0;
        dbg_grant   = 1'b0;
        mem_we      = 1'b0;
        mem_a       = '0;
        mem_d       = '0;

        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_a     = clr_cnt_q;
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                // A request still high during its own ack cycle is stale.
                dbg_live = dbg_req & ~dbg_ack_q;

                if (cpu_req && dbg_live) begin
                    // Contested: pointer holder wins, pointer passes to loser.
                    cpu_grant = ~prio_q;
                    dbg_grant = prio_q;
                    prio_d    = ~prio_q;
                end else begin
                    cpu_grant = cpu_req;
                    dbg_grant = dbg_live;
                end

                if (cpu_grant) begin
                    mem_we = cpu_we;
                    mem_a  = cpu_addr[ADDR_W-1:0];
                    mem_d  = cpu_wdata;
                end else if (dbg_grant) begin
                    mem_we      = dbg_we;
                    mem_a       = dbg_addr;
                    mem_d       = dbg_wdata;
                    dbg_ack_d   = 1'b1;
                    dbg_rdata_d = mem_spo;
                end
            end

            default: begin
                state_d = RESET_STATE;
            end
        endcase

        cpu_stall = cpu_req & ~cpu_grant;

        // No RAM write may slip through while reset is held.
        if (rst) begin
            mem_we = 1'b0;
        end
    end

    assign cpu_rdata  = mem_spo;
    assign dbg_rdata  = dbg_rdata_q;
    assign dbg_ack    = dbg_ack_q;
    assign busy_clear = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: reset clear, directed vector table, randomized
// traffic against a rule-level reference model, reset mid-clear, and a
// CLEAR_ON_RESET=0 instance.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst0, fill;
    logic        cr, cw, dr, dw;
    logic [31:0] ca, cd, dd;
    logic [7:0]  da;

    logic [31:0] crd, drd, md, spo;
    logic        stall, ack, mwe, busy;
    logic [7:0]  ma;

    logic [31:0] crd0, drd0, md0, spo0;
    logic        stall0, ack0, mwe0, busy0;
    logic [7:0]  ma0;

    logic [31:0] ram  [256];
    logic [31:0] ram0 [256];

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cr), .cpu_we(cw), .cpu_addr(ca), .cpu_wdata(cd),
        .cpu_rdata(crd), .cpu_stall(stall),
        .dbg_req(dr), .dbg_we(dw), .dbg_addr(da), .dbg_wdata(dd),
        .dbg_rdata(drd), .dbg_ack(ack),
        .mem_we(mwe), .mem_a(ma), .mem_d(md), .mem_spo(spo),
        .busy_clear(busy)
    );

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .CLEAR_ON_RESET(1'b0)) dut0 (
        .clk(clk), .rst(rst0),
        .cpu_req(cr), .cpu_we(cw), .cpu_addr(ca), .cpu_wdata(cd),
        .cpu_rdata(crd0), .cpu_stall(stall0),
        .dbg_req(dr), .dbg_we(dw), .dbg_addr(da), .dbg_wdata(dd),
        .dbg_rdata(drd0), .dbg_ack(ack0),
        .mem_we(mwe0), .mem_a(ma0), .mem_d(md0), .mem_spo(spo0),
        .busy_clear(busy0)
    );

    // Distributed RAM models: synchronous write, asynchronous read.
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 256; i++) begin
                ram[i]  <= 32'hFFFF_FFFF;
                ram0[i] <= 32'hA5A5_0000 | 32'(i);
            end
        end else begin
            if (mwe)  ram[ma]   <= md;
            if (mwe0) ram0[ma0] <= md0;
        end
    end
    assign spo  = ram[ma];
    assign spo0 = ram0[ma0];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect n consecutive clear-write cycles starting at address 0.
    task automatic clear_run(input int n);
        for (int i = 0; i < n; i++) begin
            #4;
            chk("clr_we",    32'(mwe),   32'd1);
            chk("clr_a",     32'(ma),    32'(i));
            chk("clr_d",     md,         32'd0);
            chk("clr_stall", 32'(stall), 32'(cr));
            chk("clr_busy",  32'(busy),  32'd1);
            tick();
        end
    endtask

    typedef struct {
        logic        cr, cw;
        logic [31:0] ca, cd;
        logic        dr, dw;
        logic [7:0]  da;
        logic [31:0] dd;
        logic        e_stall, e_we;
        logic [7:0]  e_a;
        logic [31:0] e_d;
        logic        e_ack;
        logic [31:0] e_drd;
        logic        e_chk_rd;
        logic [31:0] e_crd;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic icr, input logic icw, input logic [31:0] ica, input logic [31:0] icd,
                       input logic idr, input logic idw, input logic [7:0] ida, input logic [31:0] idd,
                       input logic es, input logic ew, input logic [7:0] ea, input logic [31:0] ed,
                       input logic eack, input logic [31:0] edrd, input logic ec, input logic [31:0] ecrd);
        tv.push_back('{icr, icw, ica, icd, idr, idw, ida, idd, es, ew, ea, ed, eack, edrd, ec, ecrd});
    endtask

    // Reference model state
    logic [31:0] m_mem [256];
    logic        m_prio, m_ack;
    logic [31:0] m_drd;

    localparam logic [31:0] K = 32'h1234_5678;
    localparam logic [31:0] C = 32'hCAFE_BABE;

    initial begin
        int          nz;
        int          g;
        logic        dlive, contested, ack_now;
        logic [31:0] r;
        logic [7:0]  ea;
        logic        ewe;
        logic [31:0] ed;

        rst = 1'b1; rst0 = 1'b1; fill = 1'b1;
        cr = 1'b1; cw = 1'b0; ca = 32'h0; cd = 32'h0;
        dr = 1'b0; dw = 1'b0; da = 8'h0; dd = 32'h0;
        tick();
        fill = 1'b0;

        // reset values
        #4;
        chk("rst_we",    32'(mwe),   32'd0);
        chk("rst_busy",  32'(busy),  32'd1);
        chk("rst_stall", 32'(stall), 32'd1);
        chk("rst_ack",   32'(ack),   32'd0);
        chk("rst_drd",   drd,        32'd0);
        chk("rst0_we",   32'(mwe0),  32'd0);
        tick();

        // reset clear: 256 writes, then RUN
        rst = 1'b0;
        clear_run(256);
        #4;
        chk("post_clr_busy",  32'(busy),  32'd0);
        chk("post_clr_stall", 32'(stall), 32'd0);
        tick();
        nz = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== 32'h0) nz++;
        chk("ram_zeroed", 32'(nz), 32'd0);

        // directed vectors
        add(1'b1,1'b1,32'hFFFF_FF05,K,   1'b0,1'b0,8'h00,32'h0, 1'b0,1'b1,8'h05,K,     1'b0,32'h0, 1'b0,32'h0);
        add(1'b1,1'b0,32'h0000_0105,32'h0,1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,8'h05,32'h0, 1'b0,32'h0, 1'b1,K);
        add(1'b0,1'b0,32'h0,32'h0,        1'b1,1'b1,8'hA0,C,     1'b0,1'b1,8'hA0,C,     1'b0,32'h0, 1'b0,32'h0);
        add(1'b0,1'b0,32'h0,32'h0,        1'b1,1'b1,8'hA0,C,     1'b0,1'b0,8'h00,32'h0, 1'b1,32'h0, 1'b0,32'h0);
        add(1'b0,1'b0,32'h0,32'h0,        1'b1,1'b0,8'hA0,32'h0, 1'b0,1'b0,8'hA0,32'h0, 1'b0,32'h0, 1'b0,32'h0);
        add(1'b0,1'b0,32'h0,32'h0,        1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,8'h00,32'h0, 1'b1,C,     1'b0,32'h0);
        add(1'b0,1'b0,32'h0,32'h0,        1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,8'h00,32'h0, 1'b0,C,     1'b0,32'h0);
        // contention: both held; the ack cycle leaves the CPU uncontested
        add(1'b1,1'b0,32'h05,32'h0, 1'b1,1'b0,8'hA0,32'h0, 1'b0,1'b0,8'h05,32'h0, 1'b0,C, 1'b1,K);
        add(1'b1,1'b0,32'h05,32'h0, 1'b1,1'b0,8'hA0,32'h0, 1'b1,1'b0,8'hA0,32'h0, 1'b0,C, 1'b0,32'h0);
        add(1'b1,1'b0,32'h05,32'h0, 1'b1,1'b0,8'hA0,32'h0, 1'b0,1'b0,8'h05,32'h0, 1'b1,C, 1'b1,K);
        add(1'b1,1'b0,32'h05,32'h0, 1'b1,1'b0,8'hA0,32'h0, 1'b0,1'b0,8'h05,32'h0, 1'b0,C, 1'b1,K);
        add(1'b1,1'b0,32'h05,32'h0, 1'b1,1'b0,8'hA0,32'h0, 1'b1,1'b0,8'hA0,32'h0, 1'b0,C, 1'b0,32'h0);
        add(1'b1,1'b0,32'h05,32'h0, 1'b1,1'b0,8'hA0,32'h0, 1'b0,1'b0,8'h05,32'h0, 1'b1,C, 1'b1,K);
        add(1'b0,1'b0,32'h0,32'h0,  1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,8'h00,32'h0, 1'b0,C, 1'b0,32'h0);

        foreach (tv[i]) begin
            cr = tv[i].cr; cw = tv[i].cw; ca = tv[i].ca; cd = tv[i].cd;
            dr = tv[i].dr; dw = tv[i].dw; da = tv[i].da; dd = tv[i].dd;
            #4;
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'(tv[i].e_stall));
            chk($sformatf("v%0d_we", i),    32'(mwe),   32'(tv[i].e_we));
            chk($sformatf("v%0d_a", i),     32'(ma),    32'(tv[i].e_a));
            chk($sformatf("v%0d_d", i),     md,         tv[i].e_d);
            chk($sformatf("v%0d_ack", i),   32'(ack),   32'(tv[i].e_ack));
            chk($sformatf("v%0d_drd", i),   drd,        tv[i].e_drd);
            if (tv[i].e_chk_rd) chk($sformatf("v%0d_crd", i), crd, tv[i].e_crd);
            tick();
        end

        // randomized traffic against the reference model
        for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;
        m_mem[8'h05] = K;
        m_mem[8'hA0] = C;
        m_prio = 1'b0; m_ack = 1'b0; m_drd = C;
        dr = 1'b0;
        for (int n = 0; n < 600; n++) begin
            r  = $urandom();
            cr = r[0];
            cw = r[1];
            ca = $urandom() & 32'hFFFF_FF0F;
            cd = $urandom();
            if (!dr && r[2]) begin
                dr = 1'b1;
                dw = r[3];
                da = 8'($urandom_range(0, 15));
                dd = $urandom();
            end

            dlive     = dr && !m_ack;
            contested = cr && dlive;
            if (contested)  g = m_prio ? 2 : 1;
            else if (cr)    g = 1;
            else if (dlive) g = 2;
            else            g = 0;

            ea = 8'h0; ewe = 1'b0; ed = 32'h0;
            if (g == 1) begin ea = ca[7:0]; ewe = cw; ed = cd; end
            if (g == 2) begin ea = da;      ewe = dw; ed = dd; end

            #4;
            chk("rnd_stall", 32'(stall), 32'(cr && g != 1));
            chk("rnd_we",    32'(mwe),   32'(ewe));
            chk("rnd_a",     32'(ma),    32'(ea));
            chk("rnd_d",     md,         ed);
            chk("rnd_ack",   32'(ack),   32'(m_ack));
            chk("rnd_drd",   drd,        m_drd);
            if (g == 1 && !cw) chk("rnd_crd", crd, m_mem[ca[7:0]]);
            tick();

            ack_now = m_ack;
            if (g == 2) m_drd = m_mem[da];
            if (ewe) m_mem[ea] = ed;
            m_ack = (g == 2);
            if (contested) m_prio = ~m_prio;
            if (ack_now) dr = 1'b0;
        end

        // reset asserted mid-clear restarts the full clear
        cr = 1'b1; cw = 1'b0; ca = 32'h0; dr = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_run(100);
        rst = 1'b1;
        #4;
        chk("midrst_we",   32'(mwe),  32'd0);
        chk("midrst_busy", 32'(busy), 32'd1);
        tick();
        rst = 1'b0;
        clear_run(256);
        #4;
        chk("midrst_done_busy",  32'(busy),  32'd0);
        chk("midrst_done_stall", 32'(stall), 32'd0);
        tick();

        // CLEAR_ON_RESET=0 instance: straight to RUN, RAM untouched
        cr = 1'b1; cw = 1'b0; ca = 32'h0000_0033; dr = 1'b0;
        #4;
        chk("nc_rst_stall", 32'(stall0), 32'd0);
        chk("nc_rst_we",    32'(mwe0),   32'd0);
        chk("nc_rst_busy",  32'(busy0),  32'd0);
        tick();
        rst0 = 1'b0;
        #4;
        chk("nc_busy",  32'(busy0),  32'd0);
        chk("nc_stall", 32'(stall0), 32'd0);
        chk("nc_a",     32'(ma0),    32'h33);
        chk("nc_crd",   crd0,        32'hA5A5_0033);
        tick();
        tick();
        nz = 0;
        for (int i = 0; i < 256; i++) if (ram0[i] !== (32'hA5A5_0000 | 32'(i))) nz++;
        chk("nc_ram_untouched", 32'(nz), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
